// File: rtl/instr_fetch_reg_pkg.sv
// Shared definitions for the fetch stage: opcodes, extend-mode encodings and FSM states.
// Also imported by the control FSM, so the opcode list is broader than this stage needs.
package instr_fetch_reg_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_BR   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_reg_if.sv
// Instruction-memory read handshake between the fetch stage (master) and memory (slave).
interface instr_fetch_reg_if;
  logic [31:0] Mem_Addr;
  logic        Mem_Rd;
  logic        Mem_Ack;
  logic [31:0] Mem_RData;

  modport master (output Mem_Addr, output Mem_Rd, input Mem_Ack, input Mem_RData);
  modport slave  (input Mem_Addr, input Mem_Rd, output Mem_Ack, output Mem_RData);
endinterface

// File: rtl/instr_fetch_reg_ext_sel_decode.sv
// Opcode to immediate-extend mode map; purely combinational so the control FSM can share it.
module ext_sel_decode
  import instr_fetch_reg_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [1:0] zors
);

  // Anything not listed (R-type, jumps, loads/stores, arithmetic immediates) sign-extends.
  always_comb begin
    zors = EXT_SIGN;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: zors = EXT_ZERO;
      OP_LUI:                   zors = EXT_LUI;
      OP_BEQ, OP_BNE:           zors = EXT_BR;
      default:                  zors = EXT_SIGN;
    endcase
  end

endmodule

// File: rtl/instr_fetch_reg.sv
// Multi-cycle fetch stage: reads one word per request over a req/ack handshake and holds it
// in the instruction register, exposing the decoded fields and the extend-mode select.
module instr_fetch_reg
  import instr_fetch_reg_pkg::*;
#(
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Fetch_Req,
  input  logic                     Flush,
  input  logic [31:0]              PC,
  instr_fetch_reg_if.master        mem,
  output logic [31:0]              Instr,
  output logic [5:0]               Opcode,
  output logic [4:0]               Rs,
  output logic [4:0]               Rt,
  output logic [4:0]               Rd,
  output logic [4:0]               Shamt,
  output logic [5:0]               Funct,
  output logic [15:0]              Instr15_0,
  output logic [25:0]              Instr25_0,
  output logic [1:0]               ZorS,
  output logic                     Instr_Valid,
  output logic                     Fetch_Busy,
  output logic                     Fetch_Err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state_reg, state_next;
  logic [31:0]  ir_reg, ir_next;
  logic [1:0]   zors_reg, zors_next;
  logic [31:0]  addr_reg, addr_next;
  logic         valid_reg, valid_next;
  logic         err_reg, err_next;
  logic [7:0]   cnt_reg, cnt_next;
  logic [1:0]   dec_zors;

  ext_sel_decode u_ext_sel_decode (
    .opcode (mem.Mem_RData[31:26]),
    .zors   (dec_zors)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      ir_reg    <= RESET_INSTR;
      zors_reg  <= EXT_SIGN;
      addr_reg  <= 32'h0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= 8'h0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
      zors_reg  <= zors_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    zors_next  = zors_reg;
    addr_next  = addr_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;

    if (state_reg == IDLE) begin
      // Flush beats a simultaneous request; the request is simply dropped.
      if (Flush) begin
        ir_next    = RESET_INSTR;
        zors_next  = EXT_SIGN;
        valid_next = 1'b0;
      end else if (Fetch_Req) begin
        addr_next  = PC;
        valid_next = 1'b0;
        err_next   = 1'b0;
        cnt_next   = 8'h0;
        state_next = WAIT;
      end
    end else begin
      if (Flush) begin
        ir_next    = RESET_INSTR;
        zors_next  = EXT_SIGN;
        valid_next = 1'b0;
        state_next = IDLE;
      end else if (mem.Mem_Ack) begin
        ir_next    = mem.Mem_RData;
        zors_next  = dec_zors;
        valid_next = 1'b1;
        state_next = IDLE;
      end else if (cnt_reg == CNT_LAST) begin
        // IR keeps its previous contents; only the sticky error reports the abort.
        err_next   = 1'b1;
        state_next = IDLE;
      end else begin
        cnt_next   = cnt_reg + 8'd1;
      end
    end
  end

  assign Fetch_Busy   = (state_reg == WAIT);
  assign mem.Mem_Rd   = (state_reg == WAIT);
  assign mem.Mem_Addr = addr_reg;

  assign Instr       = ir_reg;
  assign Opcode      = ir_reg[31:26];
  assign Rs          = ir_reg[25:21];
  assign Rt          = ir_reg[20:16];
  assign Rd          = ir_reg[15:11];
  assign Shamt       = ir_reg[10:6];
  assign Funct       = ir_reg[5:0];
  assign Instr15_0   = ir_reg[15:0];
  assign Instr25_0   = ir_reg[25:0];
  assign ZorS        = zors_reg;
  assign Instr_Valid = valid_reg;
  assign Fetch_Err   = err_reg;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Randomised scoreboard bench for instr_fetch_reg: the driver plays control FSM and memory,
// the monitor checks every completed WAIT period against the queued expectation.
module tb_instr_fetch_reg;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Fetch_Req = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] PC = 32'h0;
  logic [31:0] Instr;
  logic [5:0]  Opcode;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [5:0]  Funct;
  logic [15:0] Instr15_0;
  logic [25:0] Instr25_0;
  logic [1:0]  ZorS;
  logic        Instr_Valid, Fetch_Busy, Fetch_Err;

  instr_fetch_reg_if mem_if ();

  always #5 Clk = ~Clk;

  instr_fetch_reg #(.TIMEOUT(TO), .RESET_INSTR(32'h0000_0000)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Fetch_Req   (Fetch_Req),
    .Flush       (Flush),
    .PC          (PC),
    .mem         (mem_if),
    .Instr       (Instr),
    .Opcode      (Opcode),
    .Rs          (Rs),
    .Rt          (Rt),
    .Rd          (Rd),
    .Shamt       (Shamt),
    .Funct       (Funct),
    .Instr15_0   (Instr15_0),
    .Instr25_0   (Instr25_0),
    .ZorS        (ZorS),
    .Instr_Valid (Instr_Valid),
    .Fetch_Busy  (Fetch_Busy),
    .Fetch_Err   (Fetch_Err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  zors;
    logic        valid;
    logic        err;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int txn = 0;

  // Reference state of what the IR side should hold.
  logic [31:0] m_ir = 32'h0;
  logic [1:0]  m_zors = 2'b00;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_zors(input logic [5:0] op);
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: return 2'b00;
      6'h0C, 6'h0D, 6'h0E:                       return 2'b01;
      6'h0F:                                     return 2'b10;
      6'h04, 6'h05:                              return 2'b11;
      default:                                   return 2'b00;
    endcase
  endfunction

  // mode: 0 ack after n cycles, 1 timeout, 2 flush+ack at cycle n, 3 flush at cycle n.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] word, input int n,
                          input int mode, input bit hold_req);
    exp_t e;
    case (mode)
      0: begin m_ir = word; m_zors = ref_zors(word[31:26]); m_valid = 1'b1; m_err = 1'b0; end
      1: begin m_valid = 1'b0; m_err = 1'b1; end
      default: begin m_ir = 32'h0; m_zors = 2'b00; m_valid = 1'b0; m_err = 1'b0; end
    endcase
    e.addr = pc; e.instr = m_ir; e.zors = m_zors; e.valid = m_valid; e.err = m_err;
    e.busy = (mode == 1) ? TO : n;
    sb.push_back(e);
    $display("txn %0d mode=%0d pc=%08h word=%08h n=%0d hold=%0d", txn, mode, pc, word, n, hold_req);
    txn++;

    Fetch_Req = 1'b1;
    PC = pc;
    @(posedge Clk); #1;
    if (!hold_req) Fetch_Req = 1'b0;
    PC = $urandom;
    if (mode == 1) begin
      mem_if.Mem_RData = $urandom;
      repeat (TO) begin @(posedge Clk); #1; end
    end else begin
      repeat (n - 1) begin @(posedge Clk); #1; end
      mem_if.Mem_RData = word;
      mem_if.Mem_Ack = (mode != 3);
      Flush = (mode >= 2);
      @(posedge Clk); #1;
      mem_if.Mem_Ack = 1'b0;
      Flush = 1'b0;
    end
    Fetch_Req = 1'b0;
  endtask

  task automatic idle_flush(input bit with_req);
    $display("txn %0d idle flush req=%0d", txn, with_req);
    txn++;
    Flush = 1'b1;
    Fetch_Req = with_req;
    PC = $urandom;
    @(posedge Clk); #1;
    Flush = 1'b0;
    Fetch_Req = 1'b0;
    m_ir = 32'h0; m_zors = 2'b00; m_valid = 1'b0;
    chk("idle_flush_busy", Fetch_Busy, 0);
    chk("idle_flush_instr", Instr, m_ir);
    chk("idle_flush_valid", Instr_Valid, m_valid);
    chk("idle_flush_zors", ZorS, m_zors);
    chk("idle_flush_err", Fetch_Err, m_err);
  endtask

  // Monitor: each time WAIT ends, compare the settled outputs against the oldest expectation.
  initial begin : monitor
    bit prev_busy;
    int busy_cnt, rd_cnt, stray_rd;
    exp_t e;
    prev_busy = 0; busy_cnt = 0; rd_cnt = 0; stray_rd = 0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        prev_busy = 0; busy_cnt = 0; rd_cnt = 0; stray_rd = 0;
      end else begin
        if (Fetch_Busy) begin
          busy_cnt++;
          if (mem_if.Mem_Rd) rd_cnt++;
        end else begin
          if (mem_if.Mem_Rd) stray_rd++;
          if (prev_busy) begin
            if (sb.size() == 0) begin
              chk("unexpected_fetch_end", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("mem_addr", mem_if.Mem_Addr, e.addr);
              chk("busy_cycles", busy_cnt, e.busy);
              chk("mem_rd_cycles", rd_cnt, e.busy);
              chk("mem_rd_idle", stray_rd, 0);
              chk("instr", Instr, e.instr);
              chk("zors", ZorS, e.zors);
              chk("instr_valid", Instr_Valid, e.valid);
              chk("fetch_err", Fetch_Err, e.err);
              chk("fields", {Opcode, Rs, Rt, Rd, Shamt, Funct}, e.instr);
              chk("imm16", Instr15_0, e.instr[15:0]);
              chk("target26", Instr25_0, e.instr[25:0]);
            end
            busy_cnt = 0; rd_cnt = 0; stray_rd = 0;
          end
        end
        prev_busy = Fetch_Busy;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [5:0] ops[16];
    logic [31:0] w;
    int mode;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    mem_if.Mem_Ack = 1'b0;
    mem_if.Mem_RData = 32'h0;

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", Instr_Valid, 0);
    chk("rst_err", Fetch_Err, 0);
    chk("rst_busy", Fetch_Busy, 0);
    chk("rst_mem_rd", mem_if.Mem_Rd, 0);
    chk("rst_mem_addr", mem_if.Mem_Addr, 32'h0);
    chk("rst_zors", ZorS, 2'b00);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // lui with a 3-cycle memory
    do_fetch(32'h0040_0000, 32'h3C01_ABCD, 3, 0, 0);
    chk("lui_imm", Instr15_0, 16'hABCD);
    chk("lui_rt", Rt, 5'd1);
    chk("lui_zors", ZorS, 2'b10);

    // back-to-back addi / ori / beq with single-cycle memory
    do_fetch(32'h0040_0004, 32'h2001_FFFF, 1, 0, 0);
    chk("b2b_valid_drop", Instr_Valid, 1);
    do_fetch(32'h0040_0008, 32'h3402_FFFF, 1, 0, 0);
    do_fetch(32'h0040_000C, 32'h1022_FFFE, 1, 0, 0);

    // timeout, then a successful fetch that must clear the error
    do_fetch(32'h0040_0010, 32'h0, 0, 1, 0);
    do_fetch(32'h0040_0014, 32'h2001_0005, 2, 0, 0);

    // flush colliding with ack
    do_fetch(32'h0040_0018, 32'h8C22_0004, 2, 2, 0);

    // request held through WAIT must not start a second fetch
    do_fetch(32'h0040_001C, 32'h3C05_1234, 3, 0, 1);
    @(posedge Clk); #1;
    chk("held_req_no_refetch", Fetch_Busy, 0);

    idle_flush(1'b1);

    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 15)];
      mode = $urandom_range(0, 9);
      if (mode <= 5)      do_fetch($urandom, w, $urandom_range(1, TO), 0, 0);
      else if (mode == 6) do_fetch($urandom, w, 0, 1, 0);
      else if (mode == 7) do_fetch($urandom, w, $urandom_range(1, TO), 2, 0);
      else if (mode == 8) do_fetch($urandom, w, $urandom_range(1, TO), 3, 0);
      else                idle_flush($urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
    end

    // asynchronous reset in the middle of WAIT
    do_fetch(32'h0040_0100, 32'h3C07_00FF, 1, 0, 0);
    $display("txn %0d async reset mid-WAIT", txn);
    txn++;
    Fetch_Req = 1'b1;
    PC = 32'h0040_0104;
    @(posedge Clk); #1;
    Fetch_Req = 1'b0;
    chk("pre_reset_busy", Fetch_Busy, 1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_rst_mem_rd", mem_if.Mem_Rd, 0);
    chk("async_rst_instr", Instr, 32'h0);
    chk("async_rst_valid", Instr_Valid, 0);
    chk("async_rst_zors", ZorS, 2'b00);
    chk("async_rst_busy", Fetch_Busy, 0);
    m_ir = 32'h0; m_zors = 2'b00; m_valid = 1'b0; m_err = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    do_fetch(32'h0040_0200, 32'h3843_00F0, 2, 0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge Clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
